i2s_pdm_cic: RTL

PDM-to-PCM decimator placed directly downstream of the I2S/PDM receive channel. It consumes 32-bit words of raw PDM bits through a valid/ready handshake and runs them through a 4th-order CIC decimator with programmable ratio and output scaling. It produces signed PCM samples, sign-extended to 32 bits, toward the uDMA RX FIFO. One instance serves one PDM channel.

---
 rtl/i2s_cic_pkg.sv | 35 +++
 rtl/i2s_cic_integrator.sv | 32 +++
 rtl/i2s_pdm_cic.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_cic_pkg.sv
// Shared constants, types and helpers for the I2S PDM-to-PCM CIC decimator.
package i2s_cic_pkg;

  localparam int CIC_ORDER          = 4;
  localparam int DECIM_MIN          = 2;
  localparam int DECIM_MAX          = 256;
  localparam int DEFAULT_DECIM_LOG2 = 8;

  // Integrator/comb width needed to hold R^ORDER growth plus the sign bit.
  function automatic int acc_width(input int decim_log2);
    return CIC_ORDER * decim_log2 + 1;
  endfunction

  localparam int DEFAULT_ACC_WIDTH = acc_width(DEFAULT_DECIM_LOG2);

  typedef logic [DEFAULT_ACC_WIDTH-1:0] cic_acc_t;

  typedef enum logic {
    DESER_IDLE = 1'b0,
    DESER_BUSY = 1'b1
  } deser_state_e;

  function automatic logic [8:0] clamp_decim(input logic [8:0] decim);
    logic [8:0] res;
    if (decim < 9'(DECIM_MIN)) begin
      res = 9'(DECIM_MIN);
    end else if (decim > 9'(DECIM_MAX)) begin
      res = 9'(DECIM_MAX);
    end else begin
      res = decim;
    end
    return res;
  endfunction

endpackage

// File: rtl/i2s_cic_integrator.sv
// One CIC integrator stage; sum_o exposes the next value so stages chain within one cycle.
module i2s_cic_integrator
  import i2s_cic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ACC_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] acc_r;

  assign sum_o = acc_r + din_i;
  assign acc_o = acc_r;

  // Wrapping accumulator, cleared by reset or the synchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (clr_i) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (en_i) begin
      acc_r <= sum_o;
    end
  end

endmodule

// File: rtl/i2s_pdm_cic.sv
// PDM word deserialiser + 4th-order CIC decimator producing sign-extended PCM samples.
// Define I2S_CIC_SAT_EN to saturate the scaled output instead of wrapping it.
module i2s_pdm_cic
  import i2s_cic_pkg::*;
#(
  parameter int MAX_DECIM_LOG2 = 8,
  parameter int OUT_WIDTH      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        err_o,
  input  logic        err_clr_i,
  input  logic        cfg_en_i,
  input  logic        cfg_lsbfirst_i,
  input  logic [8:0]  cfg_decim_i,
  input  logic [4:0]  cfg_shift_i
);

  localparam int ACC_WIDTH = acc_width(MAX_DECIM_LOG2);

  deser_state_e         state_r, state_s;
  logic                 srst_s;
  logic [31:0]          word_r;
  logic [4:0]           bit_cnt_r;
  logic                 accept_s, consume_s, pdm_bit_s;
  logic [ACC_WIDTH-1:0] pdm_val_s;
  logic [8:0]           decim_s, dec_cnt_r;
  logic                 tick_r;
  logic [ACC_WIDTH-1:0] int_chain_s [CIC_ORDER+1];
  logic [ACC_WIDTH-1:0] int_acc_s   [CIC_ORDER];
  logic [ACC_WIDTH-1:0] comb_s      [CIC_ORDER+1];
  logic [ACC_WIDTH-1:0] comb_dly_r  [CIC_ORDER];
  logic [OUT_WIDTH-1:0] pcm_s;
  logic [31:0]          out_data_r;
  logic                 out_valid_r, err_r, drop_s;

  assign srst_s     = ~cfg_en_i;
  assign in_ready_o = cfg_en_i & ((state_r == DESER_IDLE) | (bit_cnt_r == 5'd31));
  assign accept_s   = in_valid_i & in_ready_o;
  assign consume_s  = (state_r == DESER_BUSY) & cfg_en_i;
  assign decim_s    = clamp_decim(cfg_decim_i);

  // Deserialiser next state: stay busy across back-to-back words.
  always_comb begin
    state_s = state_r;
    case (state_r)
      DESER_IDLE: begin
        if (accept_s) state_s = DESER_BUSY;
        else          state_s = DESER_IDLE;
      end
      DESER_BUSY: begin
        if ((bit_cnt_r == 5'd31) && !accept_s) state_s = DESER_IDLE;
        else                                   state_s = DESER_BUSY;
      end
      default: state_s = DESER_IDLE;
    endcase
  end

  // Deserialiser state, captured word and bit position.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= DESER_IDLE;
      word_r    <= 32'h0000_0000;
      bit_cnt_r <= 5'd0;
    end else if (srst_s) begin
      state_r   <= DESER_IDLE;
      word_r    <= 32'h0000_0000;
      bit_cnt_r <= 5'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        word_r    <= in_data_i;
        bit_cnt_r <= 5'd0;
      end else if (consume_s) begin
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end
    end
  end

  // Current PDM bit mapped to +1 / -1.
  always_comb begin
    if (cfg_lsbfirst_i) pdm_bit_s = word_r[bit_cnt_r];
    else                pdm_bit_s = word_r[5'd31 - bit_cnt_r];
    if (pdm_bit_s) pdm_val_s = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    else           pdm_val_s = {ACC_WIDTH{1'b1}};
  end

  // Decimation counter; >= lets a reduced ratio wrap on the next bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_cnt_r <= 9'd0;
      tick_r    <= 1'b0;
    end else if (srst_s) begin
      dec_cnt_r <= 9'd0;
      tick_r    <= 1'b0;
    end else if (consume_s) begin
      if (dec_cnt_r >= decim_s - 9'd1) begin
        dec_cnt_r <= 9'd0;
        tick_r    <= 1'b1;
      end else begin
        dec_cnt_r <= dec_cnt_r + 9'd1;
        tick_r    <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  assign int_chain_s[0] = pdm_val_s;

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_int
    i2s_cic_integrator #(.WIDTH(ACC_WIDTH)) u_int (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (srst_s),
      .en_i  (consume_s),
      .din_i (int_chain_s[g]),
      .sum_o (int_chain_s[g+1]),
      .acc_o (int_acc_s[g])
    );
  end

  // Comb chain on the last integrator, one differentiator per stage.
  always_comb begin
    comb_s[0] = int_acc_s[CIC_ORDER-1];
    for (int k = 0; k < CIC_ORDER; k++) begin
      comb_s[k+1] = comb_s[k] - comb_dly_r[k];
    end
  end

  // Comb delay elements advance once per decimated sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < CIC_ORDER; k++) comb_dly_r[k] <= {ACC_WIDTH{1'b0}};
    end else if (srst_s) begin
      for (int k = 0; k < CIC_ORDER; k++) comb_dly_r[k] <= {ACC_WIDTH{1'b0}};
    end else if (tick_r) begin
      for (int k = 0; k < CIC_ORDER; k++) comb_dly_r[k] <= comb_s[k];
    end
  end

`ifdef I2S_CIC_SAT_EN
  logic [ACC_WIDTH-1:0] shifted_s;
  logic                 sat_hi_s, sat_lo_s;

  // Scale, then clamp to the signed OUT_WIDTH range.
  always_comb begin
    shifted_s = $signed(comb_s[CIC_ORDER]) >>> cfg_shift_i;
    sat_hi_s  = ~shifted_s[ACC_WIDTH-1] & (|shifted_s[ACC_WIDTH-2:OUT_WIDTH-1]);
    sat_lo_s  = shifted_s[ACC_WIDTH-1] & ~(&shifted_s[ACC_WIDTH-2:OUT_WIDTH-1]);
    if (sat_hi_s)      pcm_s = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (sat_lo_s) pcm_s = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else               pcm_s = shifted_s[OUT_WIDTH-1:0];
  end
`else
  // Scale and keep the low OUT_WIDTH bits.
  always_comb begin
    pcm_s = OUT_WIDTH'($signed(comb_s[CIC_ORDER]) >>> cfg_shift_i);
  end
`endif

  assign drop_s = tick_r & out_valid_r & ~out_ready_i;

  // Output register: a sample that finds the register full is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_r  <= 32'h0000_0000;
      out_valid_r <= 1'b0;
    end else if (srst_s) begin
      out_valid_r <= 1'b0;
    end else if (tick_r && (!out_valid_r || out_ready_i)) begin
      out_data_r  <= {{(32-OUT_WIDTH){pcm_s[OUT_WIDTH-1]}}, pcm_s};
      out_valid_r <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky overflow flag; a new drop wins over a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (drop_s) begin
      err_r <= 1'b1;
    end else if (err_clr_i) begin
      err_r <= 1'b0;
    end
  end

  assign out_data_o  = out_data_r;
  assign out_valid_o = out_valid_r;
  assign err_o       = err_r;

endmodule
